// File: rtl/worley_pkg.sv
// Shared constants, types and reset tables for the Worley feature-point animator.
package worley_pkg;

  localparam int unsigned N_POINTS_DEF  = 4;
  localparam int unsigned X_MAX_DEF     = 639;
  localparam int unsigned Y_MAX_DEF     = 479;
  localparam int unsigned V_TRIGGER_DEF = 480;

  typedef logic [9:0]        coord_t;
  typedef logic signed [3:0] vel_t;

  typedef enum logic [1:0] {IDLE, STEP, COMMIT} state_e;

  // Reset x position of point i; points past the hand-placed four spread along the axis.
  function automatic coord_t init_x(input int unsigned i);
    case (i)
      0:       init_x = coord_t'(100);
      1:       init_x = coord_t'(300);
      2:       init_x = coord_t'(500);
      3:       init_x = coord_t'(200);
      default: init_x = coord_t'((64 * i) % X_MAX_DEF);
    endcase
  endfunction

  function automatic coord_t init_y(input int unsigned i);
    case (i)
      0:       init_y = coord_t'(100);
      1:       init_y = coord_t'(200);
      2:       init_y = coord_t'(400);
      3:       init_y = coord_t'(300);
      default: init_y = coord_t'((32 * i) % Y_MAX_DEF);
    endcase
  endfunction

  // Reset velocities never include -8, so negation on a bounce always stays representable.
  function automatic vel_t init_vx(input int unsigned i);
    case (i)
      0:       init_vx = 4'sd1;
      1:       init_vx = -4'sd1;
      2:       init_vx = 4'sd2;
      3:       init_vx = -4'sd1;
      default: init_vx = 4'sd1;
    endcase
  endfunction

  function automatic vel_t init_vy(input int unsigned i);
    case (i)
      0:       init_vy = -4'sd1;
      1:       init_vy = 4'sd1;
      2:       init_vy = -4'sd1;
      3:       init_vy = -4'sd2;
      default: init_vy = 4'sd1;
    endcase
  endfunction

endpackage

// File: rtl/axis_bounce_step.sv
// One-axis position step with reflection off the 0 and max walls.
module axis_bounce_step
  import worley_pkg::*;
(
  input  coord_t     pos,
  input  vel_t       v,
  input  logic [1:0] shift,
  input  coord_t     max,
  output coord_t     pos_next,
  output vel_t       v_next
);

  logic signed [11:0] v_ext;
  logic signed [11:0] delta;
  logic signed [11:0] sum;
  logic signed [11:0] lim;

  // 12-bit signed headroom covers pos + (+-7 << 3) without overflow.
  always_comb begin
    v_ext    = {{8{v[3]}}, v};
    delta    = v_ext <<< shift;
    sum      = $signed({2'b00, pos}) + delta;
    lim      = $signed({2'b00, max});
    pos_next = sum[9:0];
    v_next   = v;
    if (sum > lim) begin
      pos_next = max;
      v_next   = -v;
    end else if (sum < 12'sd0) begin
      pos_next = '0;
      v_next   = -v;
    end
  end

endmodule

// File: rtl/worley_point_animator.sv
// Owns the Worley feature points and advances them once per frame during vertical blanking.
module worley_point_animator
  import worley_pkg::*;
#(
  parameter int unsigned N_POINTS  = N_POINTS_DEF,
  parameter int unsigned X_MAX     = X_MAX_DEF,
  parameter int unsigned Y_MAX     = Y_MAX_DEF,
  parameter int unsigned V_TRIGGER = V_TRIGGER_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [9:0]              vpos,
  input  logic                    pause,
  input  logic [1:0]              speed,
  output logic [10*N_POINTS-1:0]  points_x,
  output logic [10*N_POINTS-1:0]  points_y,
  output logic                    busy,
  output logic [15:0]             frame_cnt
);

  state_e     state;
  logic [2:0] idx;
  logic [1:0] spd_l;
  logic [9:0] vpos_prev;
  logic       trig;
  logic       last;

  // Working set is stepped point by point; the output set only moves on COMMIT.
  coord_t wx [N_POINTS];
  coord_t wy [N_POINTS];
  vel_t   vx [N_POINTS];
  vel_t   vy [N_POINTS];
  coord_t ox [N_POINTS];
  coord_t oy [N_POINTS];

  coord_t cur_x, cur_y, nxt_x, nxt_y;
  vel_t   cur_vx, cur_vy, nxt_vx, nxt_vy;

  assign trig = (vpos == 10'(V_TRIGGER)) && (vpos_prev != 10'(V_TRIGGER));
  assign last = (idx == 3'(N_POINTS - 1));

  // Select the working point addressed by idx.
  always_comb begin
    cur_x  = '0;
    cur_y  = '0;
    cur_vx = '0;
    cur_vy = '0;
    for (int i = 0; i < N_POINTS; i++) begin
      if (idx == 3'(i)) begin
        cur_x  = wx[i];
        cur_y  = wy[i];
        cur_vx = vx[i];
        cur_vy = vy[i];
      end
    end
  end

  axis_bounce_step u_step_x (
    .pos      (cur_x),
    .v        (cur_vx),
    .shift    (spd_l),
    .max      (coord_t'(X_MAX)),
    .pos_next (nxt_x),
    .v_next   (nxt_vx)
  );

  axis_bounce_step u_step_y (
    .pos      (cur_y),
    .v        (cur_vy),
    .shift    (spd_l),
    .max      (coord_t'(Y_MAX)),
    .pos_next (nxt_y),
    .v_next   (nxt_vy)
  );

  // Frame FSM: trigger detect, per-point stepping and atomic commit to the outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      frame_cnt <= '0;
      vpos_prev <= '0;
      idx       <= '0;
      spd_l     <= '0;
      for (int i = 0; i < N_POINTS; i++) begin
        wx[i] <= init_x(i);
        wy[i] <= init_y(i);
        ox[i] <= init_x(i);
        oy[i] <= init_y(i);
        vx[i] <= init_vx(i);
        vy[i] <= init_vy(i);
      end
    end else begin
      vpos_prev <= vpos;
      unique case (state)
        IDLE: begin
          if (trig) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (!pause) begin
              state <= STEP;
              busy  <= 1'b1;
              idx   <= '0;
              spd_l <= speed;
            end
          end
        end
        STEP: begin
          for (int i = 0; i < N_POINTS; i++) begin
            if (idx == 3'(i)) begin
              wx[i] <= nxt_x;
              wy[i] <= nxt_y;
              vx[i] <= nxt_vx;
              vy[i] <= nxt_vy;
            end
          end
          if (last) begin
            state <= COMMIT;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        COMMIT: begin
          for (int i = 0; i < N_POINTS; i++) begin
            ox[i] <= wx[i];
            oy[i] <= wy[i];
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < N_POINTS; g++) begin : g_out
    assign points_x[10*g +: 10] = ox[g];
    assign points_y[10*g +: 10] = oy[g];
  end

endmodule

// File: tb/tb_worley_point_animator.sv
// Bench for worley_point_animator: frame-level model checked every cycle plus literal pins.
module tb_worley_point_animator;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [9:0]    vpos;
  logic          pause;
  logic [1:0]    speed;
  logic [10*N-1:0] points_x;
  logic [10*N-1:0] points_y;
  logic          busy;
  logic [15:0]   frame_cnt;

  worley_point_animator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vpos      (vpos),
    .pause     (pause),
    .speed     (speed),
    .points_x  (points_x),
    .points_y  (points_y),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame-level model: a whole frame's motion is computed at the trigger, then
  // revealed on the outputs N+1 cycles later.
  int ix [N] = '{100, 300, 500, 200};
  int iy [N] = '{100, 200, 400, 300};
  int ivx[N] = '{1, -1, 2, -1};
  int ivy[N] = '{-1, 1, -1, -2};

  int m_px[N], m_py[N], m_vx[N], m_vy[N], m_ox[N], m_oy[N];
  int m_busy, m_frame, m_vprev;

  function automatic int step_pos(input int p, input int v, input int sh, input int mx);
    int n;
    n = p + v * (1 << sh);
    if (n > mx) return mx;
    if (n < 0) return 0;
    return n;
  endfunction

  function automatic int step_vel(input int p, input int v, input int sh, input int mx);
    int n;
    n = p + v * (1 << sh);
    if (n > mx || n < 0) return -v;
    return v;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_px[i] <= ix[i];  m_py[i] <= iy[i];
        m_ox[i] <= ix[i];  m_oy[i] <= iy[i];
        m_vx[i] <= ivx[i]; m_vy[i] <= ivy[i];
      end
      m_busy  <= 0;
      m_frame <= 0;
      m_vprev <= 0;
    end else begin
      m_vprev <= int'(vpos);
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          for (int i = 0; i < N; i++) begin
            m_ox[i] <= m_px[i];
            m_oy[i] <= m_py[i];
          end
        end
      end else if (int'(vpos) == 480 && m_vprev != 480) begin
        m_frame <= (m_frame + 1) & 32'hFFFF;
        if (!pause) begin
          for (int i = 0; i < N; i++) begin
            m_px[i] <= step_pos(m_px[i], m_vx[i], int'(speed), 639);
            m_vx[i] <= step_vel(m_px[i], m_vx[i], int'(speed), 639);
            m_py[i] <= step_pos(m_py[i], m_vy[i], int'(speed), 479);
            m_vy[i] <= step_vel(m_py[i], m_vy[i], int'(speed), 479);
          end
          m_busy <= N + 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", int'(busy), int'(m_busy != 0));
      chk("frame_cnt", int'(frame_cnt), m_frame);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("x[%0d]", i), int'(points_x[10*i +: 10]), m_ox[i]);
        chk($sformatf("y[%0d]", i), int'(points_y[10*i +: 10]), m_oy[i]);
      end
    end
  end

  // One frame trigger with a fixed observation window; counts busy cycles seen.
  task automatic run_frame(output int busy_cycles);
    @(negedge clk) vpos = 10'd479;
    @(negedge clk) vpos = 10'd480;
    busy_cycles = 0;
    repeat (N + 4) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    vpos = 10'd0;
    @(negedge clk);
  endtask

  int bc;

  initial begin
    rst_n = 1'b0;
    vpos  = 10'd0;
    pause = 1'b0;
    speed = 2'd0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst x0", int'(points_x[9:0]), 100);
    chk("rst y0", int'(points_y[9:0]), 100);
    chk("rst x1", int'(points_x[19:10]), 300);
    chk("rst busy", int'(busy), 0);
    chk("rst frame", int'(frame_cnt), 0);

    // One frame at speed 0
    run_frame(bc);
    chk("f1 busy cycles", bc, 5);
    chk("f1 x0", int'(points_x[9:0]), 101);
    chk("f1 y0", int'(points_y[9:0]), 99);
    chk("f1 x1", int'(points_x[19:10]), 299);
    chk("f1 y1", int'(points_y[19:10]), 201);
    chk("f1 x2", int'(points_x[29:20]), 502);
    chk("f1 y2", int'(points_y[29:20]), 399);
    chk("f1 x3", int'(points_x[39:30]), 199);
    chk("f1 y3", int'(points_y[39:30]), 298);
    chk("f1 frame", int'(frame_cnt), 1);

    // Right-wall bounce of P2 at speed 3 (step 16)
    speed = 2'd3;
    repeat (8) run_frame(bc);
    chk("bounce pre x2", int'(points_x[29:20]), 630);
    run_frame(bc);
    chk("bounce hit x2", int'(points_x[29:20]), 639);
    run_frame(bc);
    chk("bounce back x2", int'(points_x[29:20]), 623);
    chk("bounce frame", int'(frame_cnt), 11);

    // Pause with vpos held at the trigger line
    pause = 1'b1;
    @(negedge clk) vpos = 10'd479;
    @(negedge clk) vpos = 10'd480;
    repeat (100) @(negedge clk);
    chk("pause frame", int'(frame_cnt), 12);
    chk("pause busy", int'(busy), 0);
    chk("pause x2", int'(points_x[29:20]), 623);
    vpos  = 10'd0;
    pause = 1'b0;
    @(negedge clk);

    // Retrigger while busy is ignored
    speed = 2'd0;
    @(negedge clk) vpos = 10'd479;
    @(negedge clk) vpos = 10'd480;
    @(negedge clk) vpos = 10'd481;
    @(negedge clk) vpos = 10'd480;
    @(negedge clk) vpos = 10'd481;
    repeat (N + 4) @(negedge clk);
    chk("retrig frame", int'(frame_cnt), 13);
    chk("retrig x2", int'(points_x[29:20]), 621);
    vpos = 10'd0;
    @(negedge clk);

    // Reset on the second STEP cycle
    @(negedge clk) vpos = 10'd479;
    @(negedge clk) vpos = 10'd480;
    @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    chk("midrst x0", int'(points_x[9:0]), 100);
    chk("midrst x2", int'(points_x[29:20]), 500);
    chk("midrst y3", int'(points_y[39:30]), 300);
    chk("midrst busy", int'(busy), 0);
    chk("midrst frame", int'(frame_cnt), 0);
    rst_n = 1'b1;
    vpos  = 10'd0;
    repeat (2) @(negedge clk);

    // Motion resumes cleanly from the init table
    run_frame(bc);
    chk("post x0", int'(points_x[9:0]), 101);
    chk("post frame", int'(frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/worley_point_animator.md
Name: worley_point_animator

Overview:
- Upstream stage of the Worley noise generator: owns the N feature points (position and velocity) and advances them once per frame.
- Updates run only during vertical blanking, so point coordinates never change while pixels are being drawn.
- Points bounce off the screen edges. Speed and pause are controlled from ui_in bits.
- Outputs are flat packed coordinate buses that drive the noise generator's point inputs directly.

Parameters:
- N_POINTS, 4, number of feature points (1..8).
- X_MAX, 639, largest legal x coordinate.
- Y_MAX, 479, largest legal y coordinate.
- V_TRIGGER, 480, vpos value whose first appearance starts an update (first blanking line).

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  synchronous active-low reset
- vpos  input  10  current line from hvsync_generator
- pause  input  1  1 = freeze point motion
- speed  input  2  step shift: step = velocity << speed
- points_x  output  10*N_POINTS  point i x at bits [10i+9:10i]
- points_y  output  10*N_POINTS  point i y at bits [10i+9:10i]
- busy  output  1  update in progress
- frame_cnt  output  16  count of accepted triggers

Behaviour:
- Reset: synchronous, active-low. On any clk edge with rst_n=0:
  - FSM goes to IDLE; busy=0; frame_cnt=0; vpos_prev=0.
  - Working and output positions load the init tables: P0(100,100), P1(300,200), P2(500,400), P3(200,300); points beyond 3 load (64i mod X_MAX, 32i mod Y_MAX).
  - Velocities load the init tables: V0(+1,-1), V1(-1,+1), V2(+2,-1), V3(-1,-2); points beyond 3 load (+1,+1).
  - Velocities are 4-bit signed.
  - Reset asserted mid-update abandons the update with no partial commit.
- Trigger:
  - vpos_prev is registered every cycle.
  - trig = (vpos == V_TRIGGER) && (vpos_prev != V_TRIGGER), a single-cycle pulse per frame.
  - trig is ignored while busy=1; frame_cnt is not incremented in that case.
- FSM states: IDLE, STEP, COMMIT.
  - IDLE: on trig, frame_cnt increments (wraps at 0xFFFF→0).
    - pause=1: stay in IDLE, no motion.
    - pause=0: go to STEP with idx=0 and latch speed into spd_l.
  - STEP: one point per cycle. Update working x/vx and y/vy of point idx via the axis rule below. When idx = N_POINTS-1, go to COMMIT; otherwise increment idx.
  - COMMIT: copy all working positions to the output registers in one cycle, then go to IDLE.
- Latency:
  - trig sampled at edge T.
  - STEP occupies edges T+1..T+N.
  - COMMIT occurs at edge T+N+1; new points are visible after that edge.
  - busy is high from after edge T until after edge T+N+1 (N+1 cycles).
- Output stability: points_x and points_y change only at the COMMIT edge.
- Axis rule (per axis, MAX = X_MAX or Y_MAX):
  - Compute in 12-bit signed: n = pos + (v <<< spd_l).
  - If n > MAX: pos = MAX, v = -v.
  - Else if n < 0: pos = 0, v = -v.
  - Else pos = n[9:0], v unchanged.
  - Exactly hitting 0 or MAX does not bounce.
  - v = -8 is never produced; init tables avoid it, and negation of legal values stays legal.
- Speed and pause changes mid-update take effect at the next trigger only.

Decomposition:
- Package worley_pkg holds:
  - Constants: N_POINTS default, X_MAX, Y_MAX, V_TRIGGER.
  - Init position and velocity tables as functions of index.
  - State enum {IDLE, STEP, COMMIT}.
  - Typedefs: coord_t (10-bit unsigned), vel_t (4-bit signed).
- Sub-module axis_bounce_step: combinational, inputs pos, v, shift, max; outputs next pos and next v. Instantiated twice (x and y).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release → points_x[9:0]=100, points_y[9:0]=100, points_x[19:10]=300, busy=0, frame_cnt=0.
- One frame, speed=0: drive vpos 479→480 → busy high for 5 cycles; afterwards P0=(101,99), P1=(299,201), P2=(502,399), P3=(199,298); frame_cnt=1; outputs unchanged before the COMMIT edge.
- Right-wall bounce: run frames at speed=3 until P2 x would exceed 639 → P2 x=639 and vx=-2; the next frame gives x=623.
- Pause: pause=1, trigger → positions unchanged, busy stays 0, frame_cnt increments. Holding vpos at 480 for 100 cycles gives only one count.
- Retrigger while busy: force a vpos 480→481→480 pulse during STEP → ignored; frame_cnt +1 total; a single update is applied.
- Reset mid-update: assert rst_n=0 on the second STEP cycle → next cycle outputs equal the init table, busy=0, frame_cnt=0.
